instr_fetch_unit: RTL and testbench

//  Upstream neighbour of the unified memory cache's instruction side: owns the PC and issues fetch addresses.

---
 rtl/instr_fetch_unit_pkg.sv | 17 +
 rtl/instr_fetch_unit_queue.sv | 76 +++++++
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg
//   Constants and helpers shared by the instruction fetch unit and its queue.
//   INSTR_WIDTH : width of one fetched instruction word
//   OPCODE_JAL  : RV32 opcode of JAL, the only statically predicted-taken jump
//   j_imm()     : sign-extended J-type immediate, built from instruction bits [31:12]
package instr_fetch_unit_pkg;

  localparam int         INSTR_WIDTH = 32;
  localparam logic [6:0] OPCODE_JAL  = 7'b1101111;

  // The J-immediate is scattered over bits [31:12]. Only those bits are passed in,
  // so every argument bit is used. Bit 0 of the offset is always zero.
  function automatic logic [31:0] j_imm(input logic [31:12] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// instr_fetch_unit_queue
//   Circular FIFO that holds fetched {instr, pc, predicted next pc} entries
//   until decode takes them.
//   Ports:
//     clk        in   clock
//     rst_n      in   synchronous active-low reset (clears pointers and storage)
//     flush      in   drops every entry; overrides push and pop
//     push       in   enqueue push_data (ignored when full)
//     push_data  in   entry to store
//     pop        in   dequeue the head (ignored when empty)
//     head_data  out  entry at the head
//     empty      out  no entries held
//     full       out  all 2**QUEUE_WIDTH entries held
module instr_fetch_unit_queue #(
  parameter int DATA_WIDTH  = 66,
  parameter int QUEUE_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  empty,
  output logic                  full
);

  localparam int                 DEPTH      = 1 << QUEUE_WIDTH;
  localparam logic [QUEUE_WIDTH:0] FULL_COUNT = {1'b1, {QUEUE_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [QUEUE_WIDTH-1:0] head;
  logic [QUEUE_WIDTH-1:0] tail;
  logic [QUEUE_WIDTH:0]   count;
  logic                   do_push;
  logic                   do_pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[head];

  // Storage is cleared on reset so the head outputs read as zero afterwards.
  // A flush only resets the pointers; stale entries are never visible because
  // empty gates the consumer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= push_data;
        tail      <= tail + 1'b1;
      end
      if (do_pop) begin
        head <= head + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Owns the PC, issues fetch requests to the instruction side of the cache,
//   statically predicts JAL as taken (everything else PC+4) and buffers fetched
//   words with their PC and predicted next PC for decode.
//   Ports:
//     clkIn           in   clock
//     resetIn         in   synchronous active-low reset
//     readyIn         in   CPU ready; low freezes all state
//     cacheReqValid   out  fetch request valid
//     cacheReqAddr    out  fetch address (always the PC)
//     cacheInstrValid in   fetched word valid for cacheReqAddr
//     cacheInstr      in   fetched word
//     redirectValid   in   branch resolution redirect (flushes the queue)
//     redirectPc      in   corrected next PC
//     issueValid      out  queue head valid
//     issueReady      in   consumer takes the head
//     issueInstr      out  head instruction
//     issuePc         out  head PC
//     issuePredPc     out  head predicted next PC
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                   ADDR_WIDTH  = 17,
  parameter int                   QUEUE_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                   clkIn,
  input  logic                   resetIn,
  input  logic                   readyIn,
  output logic                   cacheReqValid,
  output logic [ADDR_WIDTH-1:0]  cacheReqAddr,
  input  logic                   cacheInstrValid,
  input  logic [INSTR_WIDTH-1:0] cacheInstr,
  input  logic                   redirectValid,
  input  logic [ADDR_WIDTH-1:0]  redirectPc,
  output logic                   issueValid,
  input  logic                   issueReady,
  output logic [INSTR_WIDTH-1:0] issueInstr,
  output logic [ADDR_WIDTH-1:0]  issuePc,
  output logic [ADDR_WIDTH-1:0]  issuePredPc
);

  localparam int ENTRY_WIDTH = INSTR_WIDTH + 2 * ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  next_pc;
  logic [31:0]            offset;
  logic [31:0]            target_sum;
  logic                   unused_sum_hi;
  logic                   q_empty;
  logic                   q_full;
  logic                   push;
  logic                   pop;
  logic                   flush;
  logic [ENTRY_WIDTH-1:0] head_entry;

  // Prediction adder: the sum is formed at 32 bits and truncated, so a
  // backwards jump below address zero wraps to the top of the address space.
  assign offset        = (cacheInstr[6:0] == OPCODE_JAL) ? j_imm(cacheInstr[31:12]) : 32'd4;
  assign target_sum    = {{(32 - ADDR_WIDTH){1'b0}}, pc} + offset;
  assign next_pc       = target_sum[ADDR_WIDTH-1:0];
  assign unused_sum_hi = ^target_sum[31:ADDR_WIDTH];

  // Request and issue are gated by reset directly so a reset in the middle of
  // a miss drops the request in the same cycle. Full is the registered count,
  // so a pop cannot open a slot for a push in the same cycle.
  assign cacheReqValid = resetIn & readyIn & ~q_full;
  assign cacheReqAddr  = pc;
  assign issueValid    = resetIn & readyIn & ~q_empty;

  assign flush = redirectValid & readyIn;
  assign push  = cacheReqValid & cacheInstrValid & ~redirectValid;
  assign pop   = issueValid & issueReady & ~redirectValid;

  // A redirect wins over a fetch that completes in the same cycle.
  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      pc <= RESET_PC;
    end else if (flush) begin
      pc <= redirectPc;
    end else if (push) begin
      pc <= next_pc;
    end
  end

  instr_fetch_unit_queue #(
    .DATA_WIDTH (ENTRY_WIDTH),
    .QUEUE_WIDTH(QUEUE_WIDTH)
  ) u_queue (
    .clk      (clkIn),
    .rst_n    (resetIn),
    .flush    (flush),
    .push     (push),
    .push_data({cacheInstr, pc, next_pc}),
    .pop      (pop),
    .head_data(head_entry),
    .empty    (q_empty),
    .full     (q_full)
  );

  assign issueInstr  = head_entry[ENTRY_WIDTH-1 -: INSTR_WIDTH];
  assign issuePc     = head_entry[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign issuePredPc = head_entry[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Directed scenarios for the instruction fetch unit: reset, consecutive hits,
//   JAL prediction, queue full, redirect flush, long miss with a freeze, and
//   address wrap on a backwards JAL.
module tb_instr_fetch_unit;

  localparam int AW = 17;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] JAL_P16 = 32'h0100_006F;
  localparam logic [31:0] JAL_M8  = 32'hFF9F_F06F;

  logic          clk;
  logic          reset_n;
  logic          ready;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          instr_valid;
  logic [31:0]   instr;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          issue_valid;
  logic          issue_ready;
  logic [31:0]   issue_instr;
  logic [AW-1:0] issue_pc;
  logic [AW-1:0] issue_pred_pc;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(
    .ADDR_WIDTH (AW),
    .QUEUE_WIDTH(3),
    .RESET_PC   ('0)
  ) dut (
    .clkIn          (clk),
    .resetIn        (reset_n),
    .readyIn        (ready),
    .cacheReqValid  (req_valid),
    .cacheReqAddr   (req_addr),
    .cacheInstrValid(instr_valid),
    .cacheInstr     (instr),
    .redirectValid  (redirect_valid),
    .redirectPc     (redirect_pc),
    .issueValid     (issue_valid),
    .issueReady     (issue_ready),
    .issueInstr     (issue_instr),
    .issuePc        (issue_pc),
    .issuePredPc    (issue_pred_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ready = 1'b1; instr_valid = 1'b0; instr = NOP;
    redirect_valid = 1'b0; redirect_pc = '0; issue_ready = 1'b0;
    tick(2);
    checks++; if (req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid got=%b exp=0", req_valid); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_issue_valid got=%b exp=0", issue_valid); end
    checks++; if (req_addr !== 17'h0) begin errors++; $display("[TB] FAIL reset_pc got=%h exp=0", req_addr); end
    checks++; if (issue_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_issue_instr got=%h exp=0", issue_instr); end
    checks++; if (issue_pc !== 17'h0) begin errors++; $display("[TB] FAIL reset_issue_pc got=%h exp=0", issue_pc); end
    checks++; if (issue_pred_pc !== 17'h0) begin errors++; $display("[TB] FAIL reset_issue_pred_pc got=%h exp=0", issue_pred_pc); end
  endtask

  task automatic test_hits;
    reset_n = 1'b1; instr_valid = 1'b1; instr = NOP; issue_ready = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b1) begin errors++; $display("[TB] FAIL hits_req_valid got=%b exp=1", req_valid); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("[TB] FAIL hits_not_yet_valid got=%b exp=0", issue_valid); end
    tick();
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("[TB] FAIL hits_latency got=%b exp=1", issue_valid); end
    checks++; if (issue_pc !== 17'h0) begin errors++; $display("[TB] FAIL hits_first_pc got=%h exp=0", issue_pc); end
    checks++; if (issue_instr !== NOP) begin errors++; $display("[TB] FAIL hits_first_instr got=%h exp=%h", issue_instr, NOP); end
    checks++; if (issue_pred_pc !== 17'h4) begin errors++; $display("[TB] FAIL hits_first_pred got=%h exp=4", issue_pred_pc); end
    checks++; if (req_addr !== 17'h4) begin errors++; $display("[TB] FAIL hits_pc_step got=%h exp=4", req_addr); end
    // Push and pop every cycle: head follows one fetch behind the PC.
    issue_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (issue_pc !== 17'(4 * k)) begin errors++; $display("[TB] FAIL hits_stream_pc k=%0d got=%h exp=%h", k, issue_pc, 17'(4 * k)); end
      checks++; if (req_addr !== 17'(4 * k + 4)) begin errors++; $display("[TB] FAIL hits_stream_addr k=%0d got=%h exp=%h", k, req_addr, 17'(4 * k + 4)); end
    end
  endtask

  task automatic test_jal;
    instr = JAL_P16;
    #1;
    checks++; if (req_addr !== 17'h10) begin errors++; $display("[TB] FAIL jal_fetch_addr got=%h exp=10", req_addr); end
    tick();
    checks++; if (issue_pc !== 17'h10) begin errors++; $display("[TB] FAIL jal_issue_pc got=%h exp=10", issue_pc); end
    checks++; if (issue_instr !== JAL_P16) begin errors++; $display("[TB] FAIL jal_issue_instr got=%h exp=%h", issue_instr, JAL_P16); end
    checks++; if (issue_pred_pc !== 17'h20) begin errors++; $display("[TB] FAIL jal_pred_pc got=%h exp=20", issue_pred_pc); end
    checks++; if (req_addr !== 17'h20) begin errors++; $display("[TB] FAIL jal_next_addr got=%h exp=20", req_addr); end
    instr_valid = 1'b0; instr = NOP;
    tick();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("[TB] FAIL jal_drain got=%b exp=0", issue_valid); end
  endtask

  task automatic test_full;
    issue_ready = 1'b0; instr_valid = 1'b1; instr = NOP;
    tick(8);
    checks++; if (dut.u_queue.count !== 4'd8) begin errors++; $display("[TB] FAIL full_count got=%0d exp=8", dut.u_queue.count); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_req_valid got=%b exp=0", req_valid); end
    checks++; if (issue_pc !== 17'h20) begin errors++; $display("[TB] FAIL full_head_pc got=%h exp=20", issue_pc); end
    checks++; if (req_addr !== 17'h40) begin errors++; $display("[TB] FAIL full_pc got=%h exp=40", req_addr); end
    tick();
    checks++; if (req_addr !== 17'h40) begin errors++; $display("[TB] FAIL full_no_push got=%h exp=40", req_addr); end
    // One pop while full: no push in the same cycle, request returns after.
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    #1;
    checks++; if (dut.u_queue.count !== 4'd7) begin errors++; $display("[TB] FAIL full_pop_count got=%0d exp=7", dut.u_queue.count); end
    checks++; if (req_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_resume got=%b exp=1", req_valid); end
    checks++; if (issue_pc !== 17'h24) begin errors++; $display("[TB] FAIL full_pop_head got=%h exp=24", issue_pc); end
    checks++; if (req_addr !== 17'h40) begin errors++; $display("[TB] FAIL full_pop_pc got=%h exp=40", req_addr); end
    tick();
    checks++; if (dut.u_queue.count !== 4'd8) begin errors++; $display("[TB] FAIL full_refill got=%0d exp=8", dut.u_queue.count); end
    checks++; if (req_addr !== 17'h44) begin errors++; $display("[TB] FAIL full_refill_pc got=%h exp=44", req_addr); end
  endtask

  task automatic test_redirect;
    instr_valid = 1'b0; issue_ready = 1'b1;
    tick(3);
    checks++; if (dut.u_queue.count !== 4'd5) begin errors++; $display("[TB] FAIL redir_setup_count got=%0d exp=5", dut.u_queue.count); end
    checks++; if (issue_pc !== 17'h30) begin errors++; $display("[TB] FAIL redir_setup_head got=%h exp=30", issue_pc); end
    redirect_valid = 1'b1; redirect_pc = 17'h100; instr_valid = 1'b1;
    tick();
    redirect_valid = 1'b0; instr_valid = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_empty got=%b exp=0", issue_valid); end
    checks++; if (dut.u_queue.count !== 4'd0) begin errors++; $display("[TB] FAIL redir_count got=%0d exp=0", dut.u_queue.count); end
    checks++; if (req_addr !== 17'h100) begin errors++; $display("[TB] FAIL redir_addr got=%h exp=100", req_addr); end
    checks++; if (req_valid !== 1'b1) begin errors++; $display("[TB] FAIL redir_req got=%b exp=1", req_valid); end
    instr_valid = 1'b1; issue_ready = 1'b0;
    tick();
    checks++; if (issue_pc !== 17'h100) begin errors++; $display("[TB] FAIL redir_first_fetch got=%h exp=100", issue_pc); end
    instr_valid = 1'b0; issue_ready = 1'b1;
    tick();
  endtask

  task automatic test_miss;
    instr_valid = 1'b0; issue_ready = 1'b0;
    tick(10);
    checks++; if (req_addr !== 17'h104) begin errors++; $display("[TB] FAIL miss_addr_a got=%h exp=104", req_addr); end
    checks++; if (req_valid !== 1'b1) begin errors++; $display("[TB] FAIL miss_req_a got=%b exp=1", req_valid); end
    checks++; if (dut.u_queue.count !== 4'd0) begin errors++; $display("[TB] FAIL miss_count_a got=%0d exp=0", dut.u_queue.count); end
    // Frozen: a word and a redirect presented while not ready change nothing.
    ready = 1'b0; instr_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 17'h200;
    tick(5);
    checks++; if (req_valid !== 1'b0) begin errors++; $display("[TB] FAIL freeze_req got=%b exp=0", req_valid); end
    checks++; if (req_addr !== 17'h104) begin errors++; $display("[TB] FAIL freeze_addr got=%h exp=104", req_addr); end
    checks++; if (dut.u_queue.count !== 4'd0) begin errors++; $display("[TB] FAIL freeze_count got=%0d exp=0", dut.u_queue.count); end
    ready = 1'b1; instr_valid = 1'b0; redirect_valid = 1'b0;
    tick(5);
    checks++; if (req_addr !== 17'h104) begin errors++; $display("[TB] FAIL miss_addr_b got=%h exp=104", req_addr); end
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    checks++; if (issue_pc !== 17'h104) begin errors++; $display("[TB] FAIL miss_fill_pc got=%h exp=104", issue_pc); end
    checks++; if (req_addr !== 17'h108) begin errors++; $display("[TB] FAIL miss_fill_next got=%h exp=108", req_addr); end
    ready = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("[TB] FAIL freeze_issue got=%b exp=0", issue_valid); end
    ready = 1'b1; issue_ready = 1'b1;
    tick();
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1; redirect_pc = 17'h4; instr_valid = 1'b0; issue_ready = 1'b0;
    tick();
    redirect_valid = 1'b0; instr_valid = 1'b1; instr = JAL_M8;
    tick();
    checks++; if (issue_pc !== 17'h4) begin errors++; $display("[TB] FAIL wrap_issue_pc got=%h exp=4", issue_pc); end
    checks++; if (issue_pred_pc !== 17'h1FFFC) begin errors++; $display("[TB] FAIL wrap_pred got=%h exp=1fffc", issue_pred_pc); end
    checks++; if (req_addr !== 17'h1FFFC) begin errors++; $display("[TB] FAIL wrap_addr got=%h exp=1fffc", req_addr); end
    instr = NOP;
    tick();
    instr_valid = 1'b0;
    checks++; if (req_addr !== 17'h0) begin errors++; $display("[TB] FAIL wrap_top_plus4 got=%h exp=0", req_addr); end
  endtask

  initial begin
    test_reset();
    test_hits();
    test_jal();
    test_full();
    test_redirect();
    test_miss();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
